dsi_hdr_sched: RTL

- Schedules MIPI DSI packet headers from up to NUM_REQ requesters (e.g. video timing short packets, command engine, long-packet header source) onto one HS byte stream.
- Selects one requester per packet with round-robin arbitration.
- Latches the 24-bit header (DI, WC/data) and computes its ECC through a single shared ecc_gen instance.
- Emits the 4-byte header serially to the lane-byte packer under valid/ready flow control.

---
 rtl/dsi_hdr_sched.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/dsi_hdr_sched.sv
// DSI packet header scheduler: round-robin pick of one requester, ECC generation
// through one shared generator, and serial emission of the 4-byte header.
module dsi_hdr_sched #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [24*NUM_REQ-1:0]   req_hdr,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [7:0]              hdr_byte,
  output logic                    hdr_valid,
  input  logic                    hdr_ready,
  output logic                    hdr_last,
  output logic [1:0]              grant_id,
  output logic                    busy
);

  localparam int unsigned HDR_W = 24;
  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned SUM_W = IDX_W + 1;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t              state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [CNT_W-1:0]    cnt;
  logic [HDR_W-1:0]    hdr_reg;
  logic [7:0]          ecc_reg;
  logic [5:0]          ecc_par;

  logic [SUM_W-1:0]    cand;
  logic [IDX_W-1:0]    win_idx;
  logic                win_found;
  logic [HDR_W-1:0]    win_hdr;
  logic [7:0]          next_byte;

  // DSI header ECC (Hamming-modified); bits 7:6 of the ECC byte are always zero
  function automatic logic [5:0] ecc_gen(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  // Single shared ECC generator, always fed from the latched header
  assign ecc_par = ecc_gen(hdr_reg);

  // Round-robin search starting at rr_ptr, ascending with wrap
  always_comb begin
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = SUM_W'(rr_ptr) + SUM_W'(off);
      if (cand >= SUM_W'(NUM_REQ)) begin
        cand = cand - SUM_W'(NUM_REQ);
      end
      if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign win_hdr = req_hdr[HDR_W*win_idx +: HDR_W];

  always_comb begin
    req_ready = '0;
    if (state == IDLE && win_found) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  // Byte presented after the current one is accepted
  always_comb begin
    case (cnt)
      2'd0:    next_byte = hdr_reg[15:8];
      2'd1:    next_byte = hdr_reg[23:16];
      default: next_byte = ecc_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cnt       <= '0;
      hdr_reg   <= '0;
      ecc_reg   <= '0;
      hdr_byte  <= '0;
      hdr_valid <= 1'b0;
      hdr_last  <= 1'b0;
      grant_id  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            hdr_reg  <= win_hdr;
            grant_id <= 2'(win_idx);
            rr_ptr   <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          ecc_reg   <= {2'b00, ecc_par};
          cnt       <= '0;
          hdr_byte  <= hdr_reg[7:0];
          hdr_valid <= 1'b1;
          hdr_last  <= 1'b0;
          state     <= SEND;
        end
        SEND: begin
          if (hdr_ready) begin
            if (cnt == 2'd3) begin
              cnt       <= '0;
              hdr_byte  <= '0;
              hdr_valid <= 1'b0;
              hdr_last  <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              cnt      <= cnt + 1'b1;
              hdr_byte <= next_byte;
              hdr_last <= (cnt == 2'd2);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
